// File: rtl/pronoc_pkg.sv
// Shared fat-tree router definitions: up-port selection modes, FSM states
// and a width helper.
package pronoc_pkg;

  localparam int unsigned FT_SEL_DET = 0;
  localparam int unsigned FT_SEL_RR  = 1;
  localparam int unsigned FT_SEL_ADP = 2;

  typedef enum logic {
    FT_IDLE   = 1'b0,
    FT_LOCKED = 1'b1
  } ft_state_e;

  // ceil(log2(v)), never below 1 so single-entry fields still get a bit
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fattree_credit_counter.sv
// Saturating credit counter for one up port; ovf_c pulses on an
// attempted underflow or overflow.
module fattree_credit_counter
  import pronoc_pkg::*;
#(
  parameter int unsigned B  = 4,
  parameter int unsigned CW = log2(B + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          ovf_c
);

  always_comb begin
    ovf_c = ((dec && !inc) && (cnt == '0)) ||
            ((inc && !dec) && (cnt == CW'(B)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= CW'(B);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end else if (inc && !dec && (cnt != CW'(B))) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fattree_up_port_selector.sv
// Up-port selector for fat-tree routers: round-robin input arbiter, per-input
// selection lock held head-to-tail, and deterministic/RR/adaptive port choice.
module fattree_up_port_selector
  import pronoc_pkg::*;
#(
  parameter int unsigned K    = 2,
  parameter int unsigned KU   = 2,
  parameter int unsigned Kw   = log2(K),
  parameter int unsigned L    = 2,
  parameter int unsigned Lw   = log2(L),
  parameter int unsigned LKw  = L * Kw,
  parameter int unsigned B    = 4,
  parameter string       MODE = "ADAPTIVE"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [Lw-1:0]     current_layer,
  input  logic [K-1:0]      head_req,
  input  logic [K*LKw-1:0]  dest_pos,
  input  logic [K-1:0]      tail_sent,
  input  logic [KU-1:0]     up_flit_sent,
  input  logic [KU-1:0]     up_credit_in,
  output logic [K-1:0]      sel_valid,
  output logic [K*KU-1:0]   sel_oh,
  output logic              credit_err
);

  localparam int unsigned SEL = (MODE == "DETERMINISTIC") ? FT_SEL_DET :
                                (MODE == "RR")            ? FT_SEL_RR  : FT_SEL_ADP;
  localparam int unsigned CW  = log2(B + 1);
  localparam int unsigned AW  = log2(K);
  localparam int unsigned UW  = log2(KU);

  logic [CW-1:0] cnt [KU];
  logic [KU-1:0] ovf_c;

  for (genvar j = 0; j < int'(KU); j++) begin : g_cred
    fattree_credit_counter #(.B(B), .CW(CW)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .dec   (up_flit_sent[j]),
      .inc   (up_credit_in[j]),
      .cnt   (cnt[j]),
      .ovf_c (ovf_c[j])
    );
  end

  ft_state_e     state_q [K];
  ft_state_e     state_d [K];
  logic [KU-1:0] oh_q [K];
  logic [KU-1:0] oh_d [K];
  logic [AW-1:0] arb_ptr_q, arb_ptr_d;
  logic [UW-1:0] up_ptr_q, up_ptr_d;
  logic          credit_err_d;

  logic          gnt_vld;
  logic [AW-1:0] gnt_idx;
  logic [LKw-1:0] dest_sel;
  logic [Kw-1:0] digit;
  int            score [KU];
  int            adp_p, adp_best, best_s, chosen;
  logic [KU-1:0] chosen_oh;

  // Round-robin pick of one idle requester, starting at the arbiter pointer
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int o = 0; o < int'(K); o++) begin
      if (!gnt_vld && (state_q[(int'(arb_ptr_q) + o) % int'(K)] == FT_IDLE) &&
          head_req[(int'(arb_ptr_q) + o) % int'(K)]) begin
        gnt_vld = 1'b1;
        gnt_idx = AW'((int'(arb_ptr_q) + o) % int'(K));
      end
    end
  end

  // Up-port choice for the granted input
  always_comb begin
    dest_sel  = '0;
    digit     = '0;
    adp_p     = 0;
    adp_best  = 0;
    best_s    = 0;
    chosen    = 0;
    chosen_oh = '0;
    for (int j = 0; j < int'(KU); j++) score[j] = 0;

    for (int i = 0; i < int'(K); i++) begin
      if (gnt_idx == AW'(i)) dest_sel = dest_pos[i*int'(LKw) +: LKw];
    end
    for (int l = 0; l < int'(L); l++) begin
      if (current_layer == Lw'(l)) digit = dest_sel[l*int'(Kw) +: Kw];
    end

    // Free credits minus packets already locked onto each port
    for (int j = 0; j < int'(KU); j++) begin
      score[j] = int'(cnt[j]);
      for (int i = 0; i < int'(K); i++) begin
        if ((state_q[i] == FT_LOCKED) && oh_q[i][j]) score[j] = score[j] - 1;
      end
    end
    adp_best = int'(up_ptr_q);
    best_s   = score[up_ptr_q];
    for (int o = 1; o < int'(KU); o++) begin
      adp_p = (int'(up_ptr_q) + o) % int'(KU);
      if (score[adp_p] > best_s) begin
        best_s   = score[adp_p];
        adp_best = adp_p;
      end
    end

    case (SEL)
      FT_SEL_DET: chosen = int'(digit) % int'(KU);
      FT_SEL_RR:  chosen = int'(up_ptr_q);
      default:    chosen = adp_best;
    endcase
    for (int j = 0; j < int'(KU); j++) chosen_oh[j] = (chosen == j);
  end

  // Next-state for per-input locks, pointers and the sticky error
  always_comb begin
    state_d      = state_q;
    oh_d         = oh_q;
    arb_ptr_d    = arb_ptr_q;
    up_ptr_d     = up_ptr_q;
    credit_err_d = credit_err | (|ovf_c);

    for (int i = 0; i < int'(K); i++) begin
      if ((state_q[i] == FT_LOCKED) && tail_sent[i]) begin
        state_d[i] = FT_IDLE;
        oh_d[i]    = '0;
      end
      if (gnt_vld && (gnt_idx == AW'(i))) begin
        state_d[i] = FT_LOCKED;
        oh_d[i]    = chosen_oh;
      end
    end

    if (gnt_vld) begin
      arb_ptr_d = AW'((int'(gnt_idx) + 1) % int'(K));
      if (SEL == FT_SEL_RR)  up_ptr_d = UW'((int'(up_ptr_q) + 1) % int'(KU));
      if (SEL == FT_SEL_ADP) up_ptr_d = UW'((chosen + 1) % int'(KU));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(K); i++) begin
        state_q[i] <= FT_IDLE;
        oh_q[i]    <= '0;
      end
      arb_ptr_q  <= '0;
      up_ptr_q   <= '0;
      credit_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      oh_q       <= oh_d;
      arb_ptr_q  <= arb_ptr_d;
      up_ptr_q   <= up_ptr_d;
      credit_err <= credit_err_d;
    end
  end

  always_comb begin
    sel_valid = '0;
    sel_oh    = '0;
    for (int i = 0; i < int'(K); i++) begin
      sel_valid[i]                 = (state_q[i] == FT_LOCKED);
      sel_oh[i*int'(KU) +: KU]     = oh_q[i];
    end
  end

endmodule

// File: tb/tb_fattree_up_port_selector.sv
// Scoreboard bench: three selector instances (deterministic, round-robin,
// adaptive) with directed stimulus and queued expected grants.
module tb_fattree_up_port_selector;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct {
    int         idx;
    logic [7:0] oh;
    int         cyc;
  } exp_t;

  exp_t q_det[$];
  exp_t q_rr[$];
  exp_t q_adp[$];

  // deterministic: K=2 KU=2 L=3
  logic [1:0] det_layer = 2'd1;
  logic [1:0] det_head = '0, det_tail = '0, det_sent = '0, det_cred = '0;
  logic [5:0] det_dest = '0;
  logic [1:0] det_valid;
  logic [3:0] det_oh;
  logic       det_err;

  // round-robin: K=2 KU=4 L=2
  logic       rr_layer = 1'b0;
  logic [1:0] rr_head = '0, rr_tail = '0;
  logic [3:0] rr_dest = '0, rr_sent = '0, rr_cred = '0;
  logic [1:0] rr_valid;
  logic [7:0] rr_oh;
  logic       rr_err;

  // adaptive: K=2 KU=2 L=2 B=4
  logic       adp_layer = 1'b0;
  logic [1:0] adp_head = '0, adp_tail = '0, adp_sent = '0, adp_cred = '0;
  logic [3:0] adp_dest = '0;
  logic [1:0] adp_valid;
  logic [3:0] adp_oh;
  logic       adp_err;

  fattree_up_port_selector #(.K(2), .KU(2), .L(3), .B(4), .MODE("DETERMINISTIC")) u_det (
    .clk(clk), .reset(reset), .current_layer(det_layer), .head_req(det_head),
    .dest_pos(det_dest), .tail_sent(det_tail), .up_flit_sent(det_sent),
    .up_credit_in(det_cred), .sel_valid(det_valid), .sel_oh(det_oh), .credit_err(det_err)
  );

  fattree_up_port_selector #(.K(2), .KU(4), .L(2), .B(4), .MODE("RR")) u_rr (
    .clk(clk), .reset(reset), .current_layer(rr_layer), .head_req(rr_head),
    .dest_pos(rr_dest), .tail_sent(rr_tail), .up_flit_sent(rr_sent),
    .up_credit_in(rr_cred), .sel_valid(rr_valid), .sel_oh(rr_oh), .credit_err(rr_err)
  );

  fattree_up_port_selector #(.K(2), .KU(2), .L(2), .B(4), .MODE("ADAPTIVE")) u_adp (
    .clk(clk), .reset(reset), .current_layer(adp_layer), .head_req(adp_head),
    .dest_pos(adp_dest), .tail_sent(adp_tail), .up_flit_sent(adp_sent),
    .up_credit_in(adp_cred), .sel_valid(adp_valid), .sel_oh(adp_oh), .credit_err(adp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_grant(input int inst, input int idx, input logic [7:0] oh, input int dly);
    exp_t e;
    e.idx = idx;
    e.oh  = oh;
    e.cyc = cyc + dly;
    case (inst)
      0:       q_det.push_back(e);
      1:       q_rr.push_back(e);
      default: q_adp.push_back(e);
    endcase
  endtask

  task automatic sb_check(input int inst, input int idx, input logic [7:0] oh);
    exp_t e;
    logic got;
    got = 1'b0;
    e.idx = 0;
    e.oh = '0;
    e.cyc = 0;
    n_tests++;
    case (inst)
      0:       if (q_det.size() > 0) begin e = q_det.pop_front(); got = 1'b1; end
      1:       if (q_rr.size() > 0)  begin e = q_rr.pop_front();  got = 1'b1; end
      default: if (q_adp.size() > 0) begin e = q_adp.pop_front(); got = 1'b1; end
    endcase
    if (!got) begin
      n_fail++;
      $display("FAIL grant_unexpected inst%0d: input %0d oh 0x%0h at cycle %0d", inst, idx, oh, cyc);
    end else if ((e.idx != idx) || (e.oh !== oh) || (e.cyc != cyc)) begin
      n_fail++;
      $display("FAIL grant inst%0d: got input %0d oh 0x%0h cycle %0d, expected input %0d oh 0x%0h cycle %0d",
               inst, idx, oh, cyc, e.idx, e.oh, e.cyc);
    end
  endtask

  // Monitor: every new selection (sel_valid rising) is matched against the queue
  logic [1:0] det_vp = '0, rr_vp = '0, adp_vp = '0;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (det_valid[i] && !det_vp[i]) sb_check(0, i, 8'(det_oh[i*2 +: 2]));
      if (rr_valid[i]  && !rr_vp[i])  sb_check(1, i, 8'(rr_oh[i*4 +: 4]));
      if (adp_valid[i] && !adp_vp[i]) sb_check(2, i, 8'(adp_oh[i*2 +: 2]));
    end
    det_vp <= det_valid;
    rr_vp  <= rr_valid;
    adp_vp <= adp_valid;
  end

  initial begin
    tick(3);
    reset = 1'b0;
    tick();
    check("rst_det_valid", 32'(det_valid), 0);
    check("rst_rr_oh", 32'(rr_oh), 0);
    check("rst_adp_valid", 32'(adp_valid), 0);
    check("rst_adp_err", 32'(adp_err), 0);

    // Deterministic: layer-1 digit of 3'b001 is 0 -> port 0
    det_dest = 6'b001001;
    det_head = 2'b01;
    expect_grant(0, 0, 8'h01, 1);
    tick();
    det_dest = 6'b000010;
    tick(3);
    check("det_hold_oh", 32'(det_oh[1:0]), 32'h1);
    check("det_hold_valid", 32'(det_valid[0]), 1);
    det_head = 2'b00;
    det_tail = 2'b01;
    tick();
    det_tail = 2'b00;
    check("det_tail_valid", 32'(det_valid[0]), 0);
    check("det_tail_oh", 32'(det_oh[1:0]), 0);
    det_dest = 6'b010000;
    det_head = 2'b10;
    expect_grant(0, 1, 8'h02, 1);
    tick();
    det_head = 2'b00;
    det_tail = 2'b10;
    tick();
    det_tail = 2'b00;

    // Round-robin: five single-flit packets on input 1 -> ports 0,1,2,3,0
    for (int p = 0; p < 5; p++) begin
      rr_head = 2'b10;
      expect_grant(1, 1, 8'(32'd1 << (p % 4)), 1);
      tick();
      rr_head = 2'b00;
      rr_tail = 2'b10;
      tick();
      rr_tail = 2'b00;
    end

    // Adaptive: port 0 drained to 1 credit -> port 1; refilled -> port 0
    adp_sent = 2'b01;
    tick(3);
    adp_sent = 2'b00;
    adp_head = 2'b01;
    expect_grant(2, 0, 8'h02, 1);
    tick();
    adp_head = 2'b00;
    adp_cred = 2'b01;
    tick(3);
    adp_cred = 2'b00;
    adp_head = 2'b10;
    expect_grant(2, 1, 8'h01, 1);
    tick();
    adp_head = 2'b00;
    check("adp_err_clear", 32'(adp_err), 0);

    // Asynchronous reset with both inputs locked and port 0 at 1 credit
    adp_sent = 2'b01;
    tick(3);
    adp_sent = 2'b00;
    check("adp_locked_pre", 32'(adp_valid), 32'h3);
    reset = 1'b1;
    #1;
    check("rst_async_valid", 32'(adp_valid), 0);
    check("rst_async_oh", 32'(adp_oh), 0);
    tick();
    reset = 1'b0;

    // Both request: input 0 first (pointer 0), credits back at B
    adp_head = 2'b11;
    expect_grant(2, 0, 8'h01, 1);
    expect_grant(2, 1, 8'h02, 2);
    tick();
    adp_head = 2'b10;
    tick();
    adp_head = 2'b00;
    adp_tail = 2'b11;
    tick();
    adp_tail = 2'b00;

    // After serving input 0 alone, a simultaneous request goes to input 1 first
    adp_head = 2'b01;
    expect_grant(2, 0, 8'h01, 1);
    tick();
    adp_head = 2'b00;
    adp_tail = 2'b01;
    tick();
    adp_tail = 2'b00;
    adp_head = 2'b11;
    expect_grant(2, 1, 8'h02, 1);
    expect_grant(2, 0, 8'h01, 2);
    tick();
    adp_head = 2'b01;
    tick();
    adp_head = 2'b00;
    adp_tail = 2'b11;
    tick();
    adp_tail = 2'b00;

    // Send and credit together on port 1 leave it at B (tie -> pointer port 1)
    adp_sent = 2'b10;
    adp_cred = 2'b10;
    tick();
    adp_sent = 2'b00;
    adp_cred = 2'b00;
    check("adp_both_no_err", 32'(adp_err), 0);
    adp_head = 2'b10;
    expect_grant(2, 1, 8'h02, 1);
    tick();
    adp_head = 2'b00;
    adp_tail = 2'b10;
    tick();
    adp_tail = 2'b00;

    // Credit at B on port 1 saturates and flags the error
    adp_cred = 2'b10;
    tick();
    adp_cred = 2'b00;
    check("adp_err_set", 32'(adp_err), 1);
    adp_head = 2'b01;
    expect_grant(2, 0, 8'h01, 1);
    tick();
    adp_head = 2'b00;
    adp_tail = 2'b01;
    tick();
    adp_tail = 2'b00;
    tick(2);
    check("adp_err_sticky", 32'(adp_err), 1);
    check("det_err_clear", 32'(det_err), 0);
    check("rr_err_clear", 32'(rr_err), 0);

    tick(2);
    check("sb_drained", 32'(q_det.size() + q_rr.size() + q_adp.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fattree_up_port_selector.md
# fattree_up_port_selector

Parametrised up-port selection unit for leaf and intermediate routers of the generalised k-ary n-tree (fat-tree) NoC. It supports independent down radix K and up radix KU, and three selection modes: deterministic digit-based, round-robin, and credit-adaptive. The selection made on a packet's head flit is held until that packet's tail flit leaves. It sits beside the router's routing stage and supplies the up-port choice for every down input whose packet must ascend the tree.

## Interface
Parameters:
- K, 2: down ports (inputs served).
- KU, 2: up ports (≥1); may differ from K.
- Kw, log2(K) (min 1): width of one destination-address digit.
- L, 2: tree levels.
- Lw, log2(L) (min 1): layer width.
- LKw, L*Kw: destination position address width.
- B, 4: up-port buffer depth (initial credits per up port).
- MODE, "ADAPTIVE": "DETERMINISTIC" | "RR" | "ADAPTIVE".

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- current_layer, input, Lw: this router's layer (static).
- head_req, input, K: down input i holds a head flit that needs an up route.
- dest_pos, input, K*LKw: destination position of each requesting head.
- tail_sent, input, K: tail flit of input i forwarded this cycle.
- up_flit_sent, input, KU: a flit is sent on up port j (consumes 1 credit).
- up_credit_in, input, KU: credit returned on up port j.
- sel_valid, output, K: input i holds a valid selection.
- sel_oh, output, K*KU: one-hot up port for input i.
- credit_err, output, 1: sticky credit over/underflow flag.

## Operation
- Credit counters cnt[j], width log2(B+1):
  - Reset value B.
  - up_flit_sent alone: −1. up_credit_in alone: +1. Both in the same cycle: unchanged.
  - A decrement at 0 or an increment at B saturates the counter and sets credit_err. credit_err clears only on reset.
- Per-input FSM, IDLE → LOCKED:
  - IDLE: sel_valid=0, sel_oh=0.
  - One IDLE input with head_req is granted per cycle. The input arbiter is round-robin; its pointer starts at 0 after reset and moves to the grantee+1 (mod K) after each grant.
  - The granted input loads sel_oh and enters LOCKED.
  - LOCKED: sel_oh is held constant; head_req is ignored. tail_sent returns the input to IDLE.
  - A tail_sent seen in IDLE is ignored.
- Choice of up port j for the granted input i:
  - DETERMINISTIC: j = (digit current_layer of dest_pos[i]) mod KU, where digit d occupies bits [d*Kw +: Kw].
  - RR: j = up pointer. The pointer resets to 0 and advances +1 mod KU per grant.
  - ADAPTIVE: j = the port with the maximum cnt[j] minus the count of LOCKED inputs currently on j (the in-flight estimate). Ties go to the first port at or after the up pointer. The pointer advances to j+1 per grant.
- Credits are tracked in every mode, but only ADAPTIVE uses them for selection.

## Timing
- Registered outputs. A head_req sampled at edge t with the grant produces sel_valid/sel_oh high after edge t; the earliest use is cycle t+1.
- Single-flit packet: tail_sent may arrive in the first cycle sel_valid=1. The FSM is IDLE on the following cycle, and a new head is re-arbitrated one cycle later (minimum 2-cycle turnaround).
- Adaptive selection uses the counter values registered before the grant edge. Credit events in the grant cycle do not affect that choice.
- Reset mid-packet: all FSMs go to IDLE, counters to B, and both pointers to 0 immediately (asynchronous reset). Outputs are 0.
- A losing head_req must stay asserted; it is served in later cycles in round-robin order. With all K inputs requesting, each waits at most K−1 cycles.

## Structure
- The pronoc_pkg package holds the mode-select localparams (FT_SEL_DET, FT_SEL_RR, FT_SEL_ADP) and a log2 helper.
- There is one natural sub-module, fattree_credit_counter: one saturating counter per up port with an error output.
- The top module contains the input arbiter, the per-input FSMs, and the mode-dependent choice logic.

## Test plan
- DETERMINISTIC, K=KU=2, L=3, current_layer=1: head on input 0 with dest_pos=6'b00_10_01 → sel_oh[0]=2'b01 one cycle later; it is held until tail_sent, then sel_valid[0]=0.
- RR, K=2, KU=4: four sequential single-flit packets on input 1 → the chosen up ports are 0,1,2,3. A fifth packet → port 0.
- ADAPTIVE, KU=2, B=4: three up_flit_sent on port 0, then a head → port 1. Then return 3 credits on port 0 (port 1 still locked) → the next head goes to port 0.
- Simultaneous head_req on inputs 0 and 1 after reset → input 0 is granted at t+1 and input 1 at t+2. Repeating the pattern → input 1 is granted first.
- Credits: up_credit_in at cnt=B → cnt stays at 4 and credit_err=1. Simultaneous send and credit → cnt is unchanged.
- Assert reset while two inputs are LOCKED and cnt=1 → all sel_valid=0, cnt=B, and the next grant uses pointer 0.
